// File: rtl/motor_cmd_dispatcher_if.sv
// motor_cmd_dispatcher_if
//   Bundles the byte-stream and channel-load signals of the motor command
//   dispatcher.
//
//   Signals
//     rx_valid, rx_data   received UART byte, one-cycle qualifier
//     tx_busy             UART transmitter is busy
//     tx_start, tx_data   one-cycle request to transmit tx_data
//     ld_valid            one-hot, one-cycle load strobe per channel
//     ld_divider, ld_steps, ld_dir  shared command bus, valid with ld_valid
//
//   Handshake semantics: none of these paths carries back-pressure.
//   rx_valid and tx_start are single-cycle pulses, and their data is only
//   meaningful in the cycle the pulse is high. The dispatcher never pulses
//   tx_start while tx_busy is high. ld_valid is a one-cycle strobe, and the
//   ld_* bus holds its value until the next strobe.
//
//   Modports
//     master  the dispatcher side
//     slave   the UART/channel side
interface motor_cmd_dispatcher_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [9:0]  ld_valid;
  logic [14:0] ld_divider;
  logic [14:0] ld_steps;
  logic        ld_dir;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output tx_start, tx_data, ld_valid, ld_divider, ld_steps, ld_dir
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data, ld_valid, ld_divider, ld_steps, ld_dir
  );
endinterface

// File: rtl/motor_cmd_dispatcher.sv
// motor_cmd_dispatcher
//   Frames 5-byte motion commands from the UART receiver and loads each one
//   into its addressed motor channel. Each channel has a one-deep pending
//   flag. A status request (a single byte with low nibble F) is answered with
//   a 4-byte status frame, which is paced onto the UART transmitter.
//
//   Ports
//     CLK_SE_AR    system clock
//     rst          asynchronous reset, active-high
//     bus          rx/tx byte streams and channel load bus (master modport)
//     ch_active    per-channel activeMode; a rising edge clears pending
//     term         limit switches, active-low
//     pending      command loaded but not yet taken by the channel
//     err_drop     pulse: a complete packet was discarded
//     err_timeout  pulse: a partial packet was discarded on timeout
//     rxStateDbg   RX framing state, for observation
//     txStateDbg   TX status-frame state, for observation
module motor_cmd_dispatcher #(
  parameter int NUM_CH      = 10,
  parameter int TIMEOUT_CYC = 262143,
  parameter int BYTE_GAP    = 4095
) (
  input  logic                   CLK_SE_AR,
  input  logic                   rst,
  motor_cmd_dispatcher_if.master bus,
  input  logic [NUM_CH-1:0]      ch_active,
  input  logic [NUM_CH-1:0]      term,
  output logic [NUM_CH-1:0]      pending,
  output logic                   err_drop,
  output logic                   err_timeout,
  output logic [2:0]             rxStateDbg,
  output logic [2:0]             txStateDbg
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(BYTE_GAP + 1);

  typedef enum logic [2:0] {R_IDLE, R_B1, R_B2, R_B3, R_B4} rxState_t;
  typedef enum logic [2:0] {T_IDLE, T_S0, T_S1, T_S2, T_S3} txState_t;

  rxState_t rxState, rxNext;
  txState_t txState, txNext;

  logic [39:0]       cmd;
  logic [39:0]       newCmd;
  logic [3:0]        ch;
  logic [TO_W-1:0]   toCnt;
  logic [GAP_W-1:0]  gapCnt;
  logic [NUM_CH-1:0] chActiveQ;
  logic [NUM_CH-1:0] selMask;
  logic              statusReq;

  logic frameByte, lastByte, statusHit, toExpire, accept;
  logic txIssue, txLeave;
  logic [7:0] txByte;
  logic unusedCmdBits;

  assign rxStateDbg = rxState;
  assign txStateDbg = txState;

  // The fifth byte is decoded straight from the shift register's next value.
  // That lets the load strobe register on the same edge that takes the byte.
  assign newCmd  = {bus.rx_data, cmd[39:8]};
  assign selMask = NUM_CH'(1) << ch;
  assign accept  = (ch < 4'(NUM_CH)) && ((pending & selMask) == '0);
  // Bits that drop off the shift register, plus the ignored top bits.
  assign unusedCmdBits = ^{newCmd[39:35], newCmd[3:0], cmd[7:0]};

  always_comb begin
    rxNext    = rxState;
    frameByte = 1'b0;
    lastByte  = 1'b0;
    statusHit = 1'b0;
    toExpire  = 1'b0;
    if (bus.rx_valid) begin
      case (rxState)
        R_IDLE: begin
          if (bus.rx_data[3:0] == 4'hF) begin
            statusHit = 1'b1;
          end else begin
            frameByte = 1'b1;
            rxNext    = R_B1;
          end
        end
        R_B1:    begin frameByte = 1'b1; rxNext = R_B2; end
        R_B2:    begin frameByte = 1'b1; rxNext = R_B3; end
        R_B3:    begin frameByte = 1'b1; rxNext = R_B4; end
        R_B4:    begin frameByte = 1'b1; lastByte = 1'b1; rxNext = R_IDLE; end
        default: rxNext = R_IDLE;
      endcase
    end else if (rxState != R_IDLE && toCnt == '0) begin
      toExpire = 1'b1;
      rxNext   = R_IDLE;
    end
  end

  // Status bytes issue only when the gap has elapsed and the UART is idle.
  // Each byte samples pending/term in the cycle it is issued.
  always_comb begin
    txNext  = txState;
    txIssue = 1'b0;
    txLeave = 1'b0;
    txByte  = 8'h00;
    case (txState)
      T_IDLE: if (statusReq && !bus.tx_busy) begin
        txNext  = T_S0;
        txLeave = 1'b1;
      end
      T_S0: if (gapCnt == '0 && !bus.tx_busy) begin
        txIssue = 1'b1;
        txByte  = {3'b000, pending[4:0]};
        txNext  = T_S1;
      end
      T_S1: if (gapCnt == '0 && !bus.tx_busy) begin
        txIssue = 1'b1;
        txByte  = {3'b010, pending[9:5]};
        txNext  = T_S2;
      end
      T_S2: if (gapCnt == '0 && !bus.tx_busy) begin
        txIssue = 1'b1;
        txByte  = {3'b100, ~term[4:0]};
        txNext  = T_S3;
      end
      T_S3: if (gapCnt == '0 && !bus.tx_busy) begin
        txIssue = 1'b1;
        txByte  = {3'b110, ~term[9:5]};
        txNext  = T_IDLE;
      end
      default: txNext = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      rxState        <= R_IDLE;
      txState        <= T_IDLE;
      cmd            <= '0;
      ch             <= '0;
      toCnt          <= '0;
      gapCnt         <= '0;
      chActiveQ      <= '0;
      statusReq      <= 1'b0;
      pending        <= '0;
      err_drop       <= 1'b0;
      err_timeout    <= 1'b0;
      bus.tx_start   <= 1'b0;
      bus.tx_data    <= '0;
      bus.ld_valid   <= '0;
      bus.ld_divider <= '0;
      bus.ld_steps   <= '0;
      bus.ld_dir     <= 1'b0;
    end else begin
      rxState <= rxNext;
      txState <= txNext;
      if (frameByte) cmd <= newCmd;
      if (frameByte && rxState == R_IDLE) ch <= bus.rx_data[3:0];

      if (bus.rx_valid)     toCnt <= TO_W'(TIMEOUT_CYC);
      else if (toCnt != '0) toCnt <= toCnt - TO_W'(1);
      err_timeout <= toExpire;

      bus.ld_valid <= (lastByte && accept) ? selMask : '0;
      err_drop     <= lastByte && !accept;
      if (lastByte && accept) begin
        bus.ld_divider <= newCmd[18:4];
        bus.ld_steps   <= newCmd[33:19];
        bus.ld_dir     <= newCmd[34];
      end

      // A new load wins over a same-cycle clear on the same channel.
      chActiveQ <= ch_active;
      pending   <= (pending & ~(ch_active & ~chActiveQ)) |
                   ((lastByte && accept) ? selMask : '0);

      // A request that arrives while a frame is running is remembered, so
      // at most one further frame is queued.
      statusReq <= statusHit | (statusReq & ~txLeave);

      // Reloading with BYTE_GAP-1 puts consecutive tx_start pulses exactly
      // BYTE_GAP cycles apart when the UART is not the limiting factor.
      if (txIssue)           gapCnt <= GAP_W'(BYTE_GAP - 1);
      else if (gapCnt != '0) gapCnt <= gapCnt - GAP_W'(1);
      bus.tx_start <= txIssue;
      if (txIssue) bus.tx_data <= txByte;
    end
  end

endmodule
